// File: rtl/cu_phase_sequencer_pkg.sv
// Shared types and encodings for the multicycle control-unit phase sequencer.
// The state enum is shared by the sequencer and its bench-visible decode helpers.
package cu_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_IF,
      ST_ID,
      ST_ALU,
      ST_MEM,
      ST_MEM_WAIT,
      ST_RB_BR,
      ST_INT,
      ST_HALT
   } state_t;

   localparam logic [2:0] BR_HALT  = 3'b000;
   localparam logic [1:0] MEM_NONE = 2'b00;

   function automatic logic is_busy(input state_t s);
      return !(s == ST_IDLE || s == ST_HALT);
   endfunction

endpackage

// File: rtl/cu_phase_sequencer_wait_timer.sv
// Memory-wait cycle counter: cleared before MEM_WAIT, counts each waiting cycle,
// and flags the cycle whose closing edge completes MEM_TIMEOUT waits.
module cu_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = cnt_q + 1'b1;
   end

   // The count after this cycle would reach MEM_TIMEOUT, so this edge is the timeout.
   assign expired = enable && !clear && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cu_phase_sequencer.sv
// Phase-strobe sequencer for the multicycle control unit: IF/ID/ALU/MEM/RB_BR strobes,
// memory-wait stalls with timeout, halt and interrupt service.
module cu_phase_sequencer
   import cu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int ICNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        branch_opcode,
   input  logic              interrupt,
   input  logic [1:0]        mem_read,
   input  logic [1:0]        mem_write,
   input  logic              mem_ready,
   input  logic              int_ack,
   output logic              IF_clk,
   output logic              ID_clk,
   output logic              ALU_clk,
   output logic              MEM_clk,
   output logic              RB_BR_clk,
   output logic              int_req,
   output logic              halted,
   output logic              mem_err,
   output logic              busy,
   output logic [ICNT_W-1:0] instr_count
);

   state_t            state_q, state_d;
   logic              if_q, id_q, alu_q, mem_q, rb_q;
   logic              if_d, id_d, alu_d, mem_d, rb_d;
   logic              int_req_q, int_req_d;
   logic              halted_q, halted_d;
   logic              mem_err_q, mem_err_d;
   logic              busy_q, busy_d;
   logic [ICNT_W-1:0] icnt_q, icnt_d;
   logic              tmr_clear, tmr_en, tmr_expired;

   cu_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .expired(tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      mem_err_d = mem_err_q;
      icnt_d    = icnt_q;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_IF;
         ST_IF:    state_d = ST_ID;
         ST_ID:    state_d = ST_ALU;
         ST_ALU:   state_d = ST_MEM;
         ST_MEM: begin
            tmr_clear = 1'b1;
            if (mem_read != MEM_NONE || mem_write != MEM_NONE)
               state_d = ST_MEM_WAIT;
            else
               state_d = ST_RB_BR;
         end
         ST_MEM_WAIT: begin
            tmr_en = 1'b1;
            if (mem_ready) begin
               state_d = ST_RB_BR;
            end else if (tmr_expired) begin
               state_d   = ST_HALT;
               mem_err_d = 1'b1;
            end
         end
         ST_RB_BR: begin
            icnt_d = icnt_q + 1'b1;
            if (branch_opcode == BR_HALT)
               state_d = ST_HALT;
            else if (interrupt)
               state_d = ST_INT;
            else
               state_d = ST_IF;
         end
         ST_INT:   if (int_ack) state_d = ST_IF;
         ST_HALT: begin
            if (start) begin
               state_d   = ST_IF;
               mem_err_d = 1'b0;
            end
         end
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      if_d      = (state_d == ST_IF);
      id_d      = (state_d == ST_ID);
      alu_d     = (state_d == ST_ALU);
      mem_d     = (state_d == ST_MEM);
      rb_d      = (state_d == ST_RB_BR);
      int_req_d = (state_d == ST_INT);
      halted_d  = (state_d == ST_HALT);
      busy_d    = is_busy(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         if_q      <= 1'b0;
         id_q      <= 1'b0;
         alu_q     <= 1'b0;
         mem_q     <= 1'b0;
         rb_q      <= 1'b0;
         int_req_q <= 1'b0;
         halted_q  <= 1'b0;
         mem_err_q <= 1'b0;
         busy_q    <= 1'b0;
         icnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         if_q      <= if_d;
         id_q      <= id_d;
         alu_q     <= alu_d;
         mem_q     <= mem_d;
         rb_q      <= rb_d;
         int_req_q <= int_req_d;
         halted_q  <= halted_d;
         mem_err_q <= mem_err_d;
         busy_q    <= busy_d;
         icnt_q    <= icnt_d;
      end
   end

   assign IF_clk      = if_q;
   assign ID_clk      = id_q;
   assign ALU_clk     = alu_q;
   assign MEM_clk     = mem_q;
   assign RB_BR_clk   = rb_q;
   assign int_req     = int_req_q;
   assign halted      = halted_q;
   assign mem_err     = mem_err_q;
   assign busy        = busy_q;
   assign instr_count = icnt_q;

endmodule

// File: tb/tb_cu_phase_sequencer.sv
// Directed bench for cu_phase_sequencer with MEM_TIMEOUT=4 and a 4-bit instruction counter.
module tb_cu_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] branch_opcode;
   logic       interrupt;
   logic [1:0] mem_read;
   logic [1:0] mem_write;
   logic       mem_ready;
   logic       int_ack;
   logic       IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk;
   logic       int_req, halted, mem_err, busy;
   logic [3:0] instr_count;

   int vec_cnt = 0;
   int err_cnt = 0;

   cu_phase_sequencer #(
      .MEM_TIMEOUT(4),
      .ICNT_W     (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .branch_opcode(branch_opcode),
      .interrupt    (interrupt),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_ready    (mem_ready),
      .int_ack      (int_ack),
      .IF_clk       (IF_clk),
      .ID_clk       (ID_clk),
      .ALU_clk      (ALU_clk),
      .MEM_clk      (MEM_clk),
      .RB_BR_clk    (RB_BR_clk),
      .int_req      (int_req),
      .halted       (halted),
      .mem_err      (mem_err),
      .busy         (busy),
      .instr_count  (instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   function automatic logic [4:0] strb();
      return {IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; branch_opcode = 3'b011; interrupt = 1'b0;
      mem_read = 2'b00; mem_write = 2'b00; mem_ready = 1'b0; int_ack = 1'b0;
      step(); step();
      vec_cnt++;
      if (strb() !== 5'b00000) begin err_cnt++; $display("FAIL reset_strobes got=%b want=00000", strb()); end
      vec_cnt++;
      if ({int_req, halted, mem_err, busy} !== 4'b0000) begin
         err_cnt++; $display("FAIL reset_ctl got=%b want=0000", {int_req, halted, mem_err, busy});
      end
      vec_cnt++;
      if (instr_count !== 4'd0) begin err_cnt++; $display("FAIL reset_icnt got=%0d want=0", instr_count); end
      rst_n = 1'b1;
      step(); step();
      vec_cnt++;
      if ({strb(), busy} !== 6'b000000) begin err_cnt++; $display("FAIL idle_no_start got=%b want=000000", {strb(), busy}); end
   endtask

   task automatic test_alu();
      logic [4:0] want [5] = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
      start = 1'b1;
      step();
      start = 1'b0;
      vec_cnt++;
      if ({strb(), busy} !== 6'b100001) begin err_cnt++; $display("FAIL alu_start got=%b want=100001", {strb(), busy}); end
      for (int i = 0; i < 5; i++) begin
         step();
         vec_cnt++;
         if (strb() !== want[i]) begin err_cnt++; $display("FAIL alu_phase%0d got=%b want=%b", i + 1, strb(), want[i]); end
      end
      vec_cnt++;
      if (instr_count !== 4'd1) begin err_cnt++; $display("FAIL alu_icnt got=%0d want=1", instr_count); end
   endtask

   task automatic test_load();
      mem_read = 2'b11;
      step(); step(); step();
      vec_cnt++;
      if (strb() !== 5'b00010) begin err_cnt++; $display("FAIL load_mem got=%b want=00010", strb()); end
      for (int w = 1; w <= 3; w++) begin
         step();
         vec_cnt++;
         if ({strb(), busy} !== 6'b000001) begin err_cnt++; $display("FAIL load_wait%0d got=%b want=000001", w, {strb(), busy}); end
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0; mem_read = 2'b00;
      vec_cnt++;
      if (strb() !== 5'b00001) begin err_cnt++; $display("FAIL load_rb got=%b want=00001", strb()); end
      step();
      vec_cnt++;
      if (strb() !== 5'b10000) begin err_cnt++; $display("FAIL load_period8 got=%b want=10000", strb()); end
      vec_cnt++;
      if (instr_count !== 4'd2) begin err_cnt++; $display("FAIL load_icnt got=%0d want=2", instr_count); end
   endtask

   task automatic test_timeout();
      mem_write = 2'b01;
      step(); step(); step();
      for (int w = 1; w <= 4; w++) begin
         step();
         vec_cnt++;
         if ({strb(), busy, halted, mem_err} !== 8'b00000100) begin
            err_cnt++; $display("FAIL timeout_wait%0d got=%b want=00000100", w, {strb(), busy, halted, mem_err});
         end
      end
      step();
      mem_write = 2'b00;
      vec_cnt++;
      if ({strb(), busy, halted, mem_err} !== 8'b00000011) begin
         err_cnt++; $display("FAIL timeout_halt got=%b want=00000011", {strb(), busy, halted, mem_err});
      end
      vec_cnt++;
      if (instr_count !== 4'd2) begin err_cnt++; $display("FAIL timeout_icnt got=%0d want=2", instr_count); end
      start = 1'b1;
      step();
      start = 1'b0;
      vec_cnt++;
      if ({strb(), halted, mem_err} !== 7'b1000000) begin
         err_cnt++; $display("FAIL timeout_restart got=%b want=1000000", {strb(), halted, mem_err});
      end
   endtask

   task automatic test_halt();
      logic seen;
      branch_opcode = 3'b000;
      step(); step(); step(); step();
      vec_cnt++;
      if (strb() !== 5'b00001) begin err_cnt++; $display("FAIL halt_rb got=%b want=00001", strb()); end
      step();
      vec_cnt++;
      if ({halted, busy} !== 2'b10) begin err_cnt++; $display("FAIL halt_flags got=%b want=10", {halted, busy}); end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (strb() != 5'b00000 || !halted) seen = 1'b1;
      end
      vec_cnt++;
      if (seen !== 1'b0) begin err_cnt++; $display("FAIL halt_quiet got=%b want=0", seen); end
      vec_cnt++;
      if (instr_count !== 4'd3) begin err_cnt++; $display("FAIL halt_icnt got=%0d want=3", instr_count); end
      branch_opcode = 3'b011; start = 1'b1;
      step();
      start = 1'b0;
      vec_cnt++;
      if (strb() !== 5'b10000) begin err_cnt++; $display("FAIL halt_restart got=%b want=10000", strb()); end
   endtask

   task automatic test_interrupt();
      interrupt = 1'b1;
      step(); step(); step(); step();
      vec_cnt++;
      if ({strb(), int_req} !== 6'b000010) begin err_cnt++; $display("FAIL int_rb got=%b want=000010", {strb(), int_req}); end
      for (int c = 1; c <= 3; c++) begin
         step();
         interrupt = 1'b0;
         if (c == 3) int_ack = 1'b1;
         vec_cnt++;
         if ({strb(), int_req} !== 6'b000001) begin err_cnt++; $display("FAIL int_req%0d got=%b want=000001", c, {strb(), int_req}); end
      end
      step();
      int_ack = 1'b0;
      vec_cnt++;
      if ({strb(), int_req} !== 6'b100000) begin err_cnt++; $display("FAIL int_return got=%b want=100000", {strb(), int_req}); end
      interrupt = 1'b1; int_ack = 1'b1;
      step(); step(); step(); step(); step();
      interrupt = 1'b0;
      vec_cnt++;
      if ({strb(), int_req} !== 6'b000001) begin err_cnt++; $display("FAIL int_fast_req got=%b want=000001", {strb(), int_req}); end
      step();
      int_ack = 1'b0;
      vec_cnt++;
      if ({strb(), int_req} !== 6'b100000) begin err_cnt++; $display("FAIL int_fast_return got=%b want=100000", {strb(), int_req}); end
      vec_cnt++;
      if (instr_count !== 4'd5) begin err_cnt++; $display("FAIL int_icnt got=%0d want=5", instr_count); end
      interrupt = 1'b1; branch_opcode = 3'b000;
      step(); step(); step(); step(); step();
      vec_cnt++;
      if ({halted, int_req} !== 2'b10) begin err_cnt++; $display("FAIL int_vs_halt got=%b want=10", {halted, int_req}); end
      step(); step();
      vec_cnt++;
      if (int_req !== 1'b0) begin err_cnt++; $display("FAIL int_vs_halt_later got=%b want=0", int_req); end
      interrupt = 1'b0; branch_opcode = 3'b011; start = 1'b1;
      step();
      start = 1'b0;
      vec_cnt++;
      if (strb() !== 5'b10000) begin err_cnt++; $display("FAIL int_halt_restart got=%b want=10000", strb()); end
   endtask

   task automatic test_wrap();
      logic [3:0] want;
      want = 4'd6;
      for (int n = 0; n < 10; n++) begin
         repeat (5) step();
         want = want + 4'd1;
         vec_cnt++;
         if ({IF_clk, instr_count} !== {1'b1, want}) begin
            err_cnt++; $display("FAIL wrap_icnt%0d got=%b want=%b", n, {IF_clk, instr_count}, {1'b1, want});
         end
      end
   endtask

   task automatic test_async_reset();
      repeat (5) step();
      mem_read = 2'b11;
      step(); step(); step(); step(); step();
      vec_cnt++;
      if ({strb(), busy, instr_count} !== {6'b000001, 4'd1}) begin
         err_cnt++; $display("FAIL areset_pre got=%b want=%b", {strb(), busy, instr_count}, {6'b000001, 4'd1});
      end
      #2;
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({strb(), int_req, halted, mem_err, busy} !== 9'b0) begin
         err_cnt++; $display("FAIL areset_outputs got=%b want=000000000", {strb(), int_req, halted, mem_err, busy});
      end
      vec_cnt++;
      if (instr_count !== 4'd0) begin err_cnt++; $display("FAIL areset_icnt got=%0d want=0", instr_count); end
      mem_read = 2'b00;
      step();
      #2;
      rst_n = 1'b1;
      repeat (3) step();
      vec_cnt++;
      if ({strb(), busy} !== 6'b000000) begin err_cnt++; $display("FAIL areset_idle got=%b want=000000", {strb(), busy}); end
      start = 1'b1;
      step();
      start = 1'b0;
      vec_cnt++;
      if (strb() !== 5'b10000) begin err_cnt++; $display("FAIL areset_start got=%b want=10000", strb()); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_timeout();
      test_halt();
      test_interrupt();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/cu_phase_sequencer.md
# cu_phase_sequencer

Generates the five single-cycle phase strobes (IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk) that drive the multicycle control unit. It is the source end of the phase-clock interface: the sequencer emits strobes, and the control unit responds with halt (`branch_opcode`), interrupt and memory-access controls. The sequencer reads these responses back to decide whether to stall for memory, halt, or enter interrupt service. It sits between the system clock/reset and the control unit.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before a memory error; legal range 1..255.
- ICNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; one clock for the whole block.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  level; begins fetching from IDLE or HALT.
- branch_opcode  in  3  from control unit; 3'b000 means halt.
- interrupt  in  1  from control unit; MTC executed.
- mem_read  in  2  from control unit; nonzero means a load is requested.
- mem_write  in  2  from control unit; nonzero means a store is requested.
- mem_ready  in  1  from memory; access complete.
- int_ack  in  1  from interrupt handler; service done.
- IF_clk, ID_clk, ALU_clk, MEM_clk, RB_BR_clk  out  1 each  registered phase strobes; at most one is high in any cycle.
- int_req  out  1  interrupt service request.
- halted  out  1  high in HALT.
- mem_err  out  1  sticky flag; memory timeout occurred.
- busy  out  1  high in any state except IDLE and HALT.
- instr_count  out  ICNT_W  count of RB_BR strobes; wraps modulo 2^ICNT_W.

## Operation
- States: IDLE, IF, ID, ALU, MEM, MEM_WAIT, RB_BR, INT, HALT.
- The phase strobe for a state is high for exactly the single cycle spent in that state. MEM_WAIT, INT, IDLE and HALT drive no strobe.
- IDLE: go to IF when start=1.
- Fixed phase order: IF -> ID -> ALU -> MEM.
- Control-unit outputs are sampled at the clk edge that ends a strobe cycle.
- MEM: if mem_read != 0 or mem_write != 0, go to MEM_WAIT; otherwise go to RB_BR.
- MEM_WAIT:
  - mem_ready=1 at an edge: go to RB_BR.
  - Wait counter reaches MEM_TIMEOUT without mem_ready: set mem_err and go to HALT.
  - mem_ready is ignored in every other state.
- RB_BR: increment instr_count, then choose the next state by priority:
  - branch_opcode == 3'b000: go to HALT.
  - else interrupt == 1: go to INT.
  - else: go to IF.
- INT: int_req=1. When int_ack=1, go to IF and drop int_req in that same transition.
- HALT:
  - halted=1.
  - start=1: go to IF, clear halted and mem_err. instr_count is retained.
- start is ignored while busy=1.

## Timing
- Reset (asynchronous, immediate): state=IDLE. All strobes, int_req, halted, mem_err and busy are 0. instr_count=0.
- Reset mid-instruction aborts it with no partial strobe.
- Start latency: start sampled high in IDLE -> IF_clk high in the next cycle.
- Instruction period without memory access: 5 cycles from IF_clk to the next IF_clk.
- Instruction period with memory access: 5 + W cycles, where W is the number of MEM_WAIT cycles (W ≥ 1).
- mem_ready already high at the first MEM_WAIT edge gives W=1.
- Wait counter:
  - Cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle.
  - Timeout fires at the edge where the count equals MEM_TIMEOUT, so there are exactly MEM_TIMEOUT MEM_WAIT cycles.
  - mem_ready and timeout at the same edge: mem_ready wins.
- int_ack already high on INT entry: INT lasts 1 cycle, int_req pulses for one cycle.
- instr_count wraps from 2^ICNT_W-1 to 0 without any flag.
- halted is asserted in the cycle after the RB_BR_clk strobe.

## Structure
- Shared package cu_pkg:
  - State enum.
  - BR_HALT = 3'b000.
  - MEM_NONE = 2'b00.
- Sub-module cu_wait_timer:
  - Inputs: clear and enable.
  - Output: an expired pulse at MEM_TIMEOUT.
  - Parameterised by MEM_TIMEOUT; counter width is $clog2(MEM_TIMEOUT+1).
- All outputs are registered.
- Strobes are decoded from the state register; they are not combinationally derived from inputs.

## Test plan
- ALU instruction: reset, then start=1 with mem_read = mem_write = 0 and branch_opcode = 3'b011.
  - Required: strobes IF, ID, ALU, MEM, RB_BR in 5 consecutive cycles, IF again at cycle 6, instr_count=1.
- Load: mem_read = 2'b11, mem_ready raised 3 cycles after MEM_clk.
  - Required: W=3, RB_BR_clk in the cycle after mem_ready is sampled, period 8 cycles.
- Timeout: mem_write = 2'b01, mem_ready held 0, MEM_TIMEOUT=4.
  - Required: 4 MEM_WAIT cycles, then mem_err=1, halted=1, no RB_BR_clk.
  - Then start=1: mem_err=0, IF_clk in the next cycle.
- Halt: branch_opcode = 3'b000 during RB_BR.
  - Required: halted=1, busy=0, strobes stay low for 20 cycles, instr_count incremented once.
- Interrupt: interrupt=1 at RB_BR, int_ack raised 2 cycles later.
  - Required: int_req high 3 cycles, then IF_clk.
  - With interrupt=1 and branch_opcode = 3'b000 together: HALT wins, int_req stays 0.
- Async reset: drop rst_n mid-MEM_WAIT between clk edges.
  - Required: all outputs 0 immediately, instr_count=0, IDLE until start.
